// File: rtl/ibuff_pkg.sv
// Shared types and sizing constants for the instruction buffer dispatch-side controller.
package ibuff_pkg;

  localparam int IBUFF_DEPTH = 16;
  localparam int IBUFF_INDEX = 4;
  localparam int IBUFF_RPORT = 4;
  localparam int IBUFF_WPORT = 8;
  localparam int IBUFF_CNT_W = IBUFF_INDEX + 1;

  localparam int IBUFF_STALL_THRESH = IBUFF_WPORT;

  typedef logic [IBUFF_INDEX-1:0] ibuff_ptr_t;
  typedef logic [IBUFF_CNT_W-1:0] ibuff_cnt_t;

endpackage

// File: rtl/ibuff_lane_addr.sv
// Wrapped read addresses for the dispatch lanes: lane k reads (head+k) mod DEPTH.
module ibuff_lane_addr
  import ibuff_pkg::*;
#(
  parameter int INDEX = IBUFF_INDEX,
  parameter int RPORT = IBUFF_RPORT
) (
  input  logic [INDEX-1:0]       head,
  output logic [RPORT*INDEX-1:0] rd_addr
);

  for (genvar k = 0; k < RPORT; k++) begin : g_lane
    // DEPTH is a power of two, so truncating the sum wraps for free
    assign rd_addr[k*INDEX +: INDEX] = head + INDEX'(k);
  end

endmodule

// File: rtl/ibuff_dispatch_ctrl.sv
// Head/tail/occupancy controller for the instruction buffer RAM, dispatch side.
// IBUFF_PARTIAL_DISPATCH_EN enables partial bundles; otherwise dispatch is all-or-nothing.
module ibuff_dispatch_ctrl
  import ibuff_pkg::*;
#(
  parameter int DEPTH = IBUFF_DEPTH,
  parameter int INDEX = IBUFF_INDEX,
  parameter int RPORT = IBUFF_RPORT,
  parameter int WPORT = IBUFF_STALL_THRESH,
  parameter int CNT_W = INDEX + 1,
  localparam int WC_W = $clog2(WPORT + 1),
  localparam int PC_W = $clog2(RPORT + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WC_W-1:0]        wr_count_i,
  input  logic                   flush_i,
  input  logic                   dispatch_ready_i,
  output logic [INDEX-1:0]       tail_o,
  output logic [RPORT*INDEX-1:0] rd_addr_o,
  output logic [RPORT-1:0]       rd_valid_o,
  output logic [PC_W-1:0]        pop_count_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   stall_o
);

  logic [INDEX-1:0] head;
  logic [INDEX-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;

  assign free    = CNT_W'(DEPTH) - count;
  assign stall_o = free < CNT_W'(WPORT);
  assign tail_o  = tail;
  assign count_o = count;

  ibuff_lane_addr #(
    .INDEX (INDEX),
    .RPORT (RPORT)
  ) u_lane_addr (
    .head    (head),
    .rd_addr (rd_addr_o)
  );

`ifdef IBUFF_PARTIAL_DISPATCH_EN
  logic [PC_W-1:0] avail;

  assign avail = (count >= CNT_W'(RPORT)) ? PC_W'(RPORT) : PC_W'(count);

  for (genvar k = 0; k < RPORT; k++) begin : g_valid
    assign rd_valid_o[k] = PC_W'(k) < avail;
  end

  assign pop_count_o = dispatch_ready_i ? avail : '0;
`else
  logic bundle_full;

  assign bundle_full = count >= CNT_W'(RPORT);
  assign rd_valid_o  = bundle_full ? '1 : '0;
  assign pop_count_o = (dispatch_ready_i && bundle_full) ? PC_W'(RPORT) : '0;
`endif

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + INDEX'(pop_count_o);
      tail  <= tail + INDEX'(wr_count_i);
      count <= count + CNT_W'(wr_count_i) - CNT_W'(pop_count_o);
    end
  end

`ifndef SYNTHESIS
  // Fetch overrunning free space or ignoring stall corrupts the buffer silently
  always @(posedge clk) begin
    if (!reset) begin
      assert (CNT_W'(wr_count_i) <= free);
      assert (!(stall_o && (wr_count_i != '0)));
    end
  end
`endif

endmodule

// File: tb/tb_ibuff_dispatch_ctrl.sv
// Directed vector bench for ibuff_dispatch_ctrl (DEPTH=16, RPORT=4, WPORT=8).
module tb_ibuff_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wr_count_i;
  logic        flush_i;
  logic        dispatch_ready_i;
  logic [3:0]  tail_o;
  logic [15:0] rd_addr_o;
  logic [3:0]  rd_valid_o;
  logic [2:0]  pop_count_o;
  logic [4:0]  count_o;
  logic        stall_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibuff_dispatch_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .wr_count_i       (wr_count_i),
    .flush_i          (flush_i),
    .dispatch_ready_i (dispatch_ready_i),
    .tail_o           (tail_o),
    .rd_addr_o        (rd_addr_o),
    .rd_valid_o       (rd_valid_o),
    .pop_count_o      (pop_count_o),
    .count_o          (count_o),
    .stall_o          (stall_o)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic [3:0] wr;
    logic       rdy;
    int         count;
    int         tail;
    int         head;
    logic [3:0] valid;
    int         pop;
    logic       stall;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(logic rst, logic flush, int wr, logic rdy, int count,
                              int tail, int head, logic [3:0] valid, int pop, logic stall);
    vec_t v;
    v.rst = rst; v.flush = flush; v.wr = 4'(wr); v.rdy = rdy;
    v.count = count; v.tail = tail; v.head = head;
    v.valid = valid; v.pop = pop; v.stall = stall;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lanes(int head);
    logic [15:0] a;
    for (int k = 0; k < 4; k++) a[k*4 +: 4] = 4'((head + k) % 16);
    return a;
  endfunction

  task automatic drive(logic rst, logic flush, int wr, logic rdy);
    reset = rst; flush_i = flush; wr_count_i = 4'(wr); dispatch_ready_i = rdy;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Checks outputs for the current (pre-edge) state and inputs.
  task automatic expect_state(string tag, int count, int tail, int head,
                              logic [3:0] valid, int pop, logic stall);
    chk({tag, " count"}, int'(count_o), count);
    chk({tag, " tail"}, int'(tail_o), tail);
    chk({tag, " addr"}, int'(rd_addr_o), int'(lanes(head)));
    chk({tag, " valid"}, int'(rd_valid_o), int'(valid));
    chk({tag, " pop"}, int'(pop_count_o), pop);
    chk({tag, " stall"}, int'(stall_o), int'(stall));
  endtask

  initial begin
    //            rst flush wr rdy   count tail head valid   pop stall
    vt[0]  = mk(0, 0, 0, 0,   0,  0,  0, 4'b0000, 0, 0);
    vt[1]  = mk(0, 0, 8, 0,   0,  0,  0, 4'b0000, 0, 0);
    vt[2]  = mk(0, 0, 8, 0,   8,  8,  0, 4'b1111, 0, 0);
    vt[3]  = mk(0, 0, 0, 1,  16,  0,  0, 4'b1111, 4, 1);
    vt[4]  = mk(0, 0, 0, 1,  12,  0,  4, 4'b1111, 4, 1);
    vt[5]  = mk(0, 0, 0, 0,   8,  0,  8, 4'b1111, 0, 0);
    vt[6]  = mk(0, 0, 5, 1,   8,  0,  8, 4'b1111, 4, 0);
    vt[7]  = mk(0, 0, 0, 1,   9,  5, 12, 4'b1111, 4, 1);
    vt[8]  = mk(0, 0, 6, 1,   5,  5,  0, 4'b1111, 4, 0);
    vt[9]  = mk(0, 0, 0, 0,   7, 11,  4, 4'b1111, 0, 0);
    vt[10] = mk(0, 1, 4, 1,   7, 11,  4, 4'b1111, 4, 0);
    vt[11] = mk(0, 0, 0, 0,   0,  0,  0, 4'b0000, 0, 0);
    vt[12] = mk(0, 0, 8, 0,   0,  0,  0, 4'b0000, 0, 0);
    vt[13] = mk(1, 1, 4, 1,   8,  8,  0, 4'b1111, 4, 0);
    vt[14] = mk(0, 0, 0, 0,   0,  0,  0, 4'b0000, 0, 0);

    drive(1, 0, 0, 0);
    tick();
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].rst, vt[i].flush, int'(vt[i].wr), vt[i].rdy);
      expect_state($sformatf("vec%0d", i), vt[i].count, vt[i].tail, vt[i].head,
                   vt[i].valid, vt[i].pop, vt[i].stall);
      tick();
    end

    // Partial bundle of 3 with the backend ready
    drive(0, 0, 3, 0);
    tick();
    drive(0, 0, 0, 1);
`ifdef IBUFF_PARTIAL_DISPATCH_EN
    expect_state("part3", 3, 3, 0, 4'b0111, 3, 0);
    tick();
    drive(0, 0, 0, 0);
    expect_state("part3_after", 0, 3, 3, 4'b0000, 0, 0);
`else
    expect_state("part3", 3, 3, 0, 4'b0000, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    expect_state("part3_after", 3, 3, 0, 4'b0000, 0, 0);
`endif

    // Lane address wrap: bring head near the top of the buffer with 4 entries queued
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 8, 0);
    tick();
`ifdef IBUFF_PARTIAL_DISPATCH_EN
    drive(0, 0, 6, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      tick();
    end
    drive(0, 0, 4, 0);
    tick();
    drive(0, 0, 0, 1);
    expect_state("wrap", 4, 2, 14, 4'b1111, 4, 0);
    tick();
    drive(0, 0, 0, 0);
    expect_state("wrap_after", 0, 2, 2, 4'b0000, 0, 0);
`else
    drive(0, 0, 8, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    expect_state("wrap", 4, 0, 12, 4'b1111, 4, 0);
    tick();
    drive(0, 0, 0, 0);
    expect_state("wrap_after", 0, 0, 0, 4'b0000, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibuff_dispatch_ctrl.md
# ibuff_dispatch_ctrl

Pointer and occupancy controller for the instruction buffer RAM: the dispatch-side reader that pairs with the fetch-side writer. Tracks head, tail and occupancy of the circular buffer. Drives up to RPORT read addresses per cycle toward dispatch, and retires (pops) the bundle when the backend accepts it. Gives the fetch side its write base (tail) and a stall when fewer than WPORT slots are free.

## Interface
- DEPTH, 16, buffer entries; must be a power of two
- INDEX, 4, log2(DEPTH); pointer width
- RPORT, 4, dispatch lanes (read ports)
- WPORT, 8, maximum entries written per cycle (2×fetch width)
- CNT_W, INDEX+1, occupancy counter width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous reset, active-high
- wr_count_i  in  $clog2(WPORT+1)  entries written by fetch this cycle at tail_o+0..wr_count_i-1
- flush_i  in  1  discard all buffered entries (mispredict/exception recovery)
- dispatch_ready_i  in  1  backend accepts the current bundle this cycle
- tail_o  out  INDEX  write base address for the fetch side
- rd_addr_o  out  RPORT*INDEX  lane k address = (head+k) mod DEPTH, lane 0 in LSBs
- rd_valid_o  out  RPORT  lane k holds a dispatchable instruction
- pop_count_o  out  $clog2(RPORT+1)  entries retired at this edge
- count_o  out  CNT_W  current occupancy
- stall_o  out  1  asserted when DEPTH-count < WPORT; fetch must not write

## Operation
- State: head, tail (INDEX bits, wrap by natural overflow), count (CNT_W bits, 0..DEPTH).
- rd_addr_o, rd_valid_o, stall_o, count_o and tail_o are combinational from the registers only. They never depend on the same-cycle inputs.
- avail = min(count, RPORT). Lane validity and pop_count_o follow the configuration rule below.
- pop_count_o = dispatch_ready_i ? (number of valid lanes) : 0.
- Each posedge, without flush:
  - head += pop_count_o
  - tail += wr_count_i
  - count += wr_count_i − pop_count_o
- flush_i: head, tail and count all go to 0 next cycle. Writes and pops in that cycle are discarded. reset has priority over flush_i.
- Simultaneous write and pop: both apply. Entries written this cycle are never visible to lanes in the same cycle.
- Protocol violation: wr_count_i > DEPTH−count, or wr_count_i ≠ 0 while stall_o is high. Simulation assertion fires; RTL behaviour is undefined.
- Reset values:
  - head = tail = count = 0
  - tail_o = 0, count_o = 0, stall_o = 0, rd_valid_o = 0, pop_count_o = 0
  - rd_addr_o lanes = 0,1,2,3

## Timing
- Address to data is zero-latency because the RAM read is asynchronous. Lane data is valid in the same cycle as rd_valid_o.
- Write to read: an entry written at edge N is readable in the cycle after edge N.
- Pop takes effect at the edge where dispatch_ready_i is sampled high. The next bundle is presented one cycle later.
- stall_o reflects the post-edge occupancy, so it is one cycle behind wr_count_i.
- Wrap: (head+k) and tail wrap modulo DEPTH with no extra cycle.
- Full (count = DEPTH) and empty (count = 0) are distinguished by count, never by head==tail.

## Configuration
- IBUFF_PARTIAL_DISPATCH_EN defined:
  - lanes 0..avail−1 are valid
  - a partial bundle may be popped
- IBUFF_PARTIAL_DISPATCH_EN undefined:
  - all-or-nothing dispatch
  - rd_valid_o = all ones when count ≥ RPORT, else all zeros
  - pops are exactly RPORT or 0

## Structure
- The shared ibuff package holds:
  - typedef ibuff_ptr_t (logic [INDEX-1:0])
  - typedef ibuff_cnt_t (logic [CNT_W-1:0])
  - constant IBUFF_STALL_THRESH = WPORT
- Sub-module ibuff_lane_addr: combinational generator of the RPORT wrapped lane addresses from head, instanced once.
- The controller and ibuff_lane_addr are instanced beside the buffer RAM in the fetch-to-dispatch stage.

## Test plan
Configuration for all scenarios: DEPTH=16, RPORT=4, WPORT=8.
1. Reset, then idle:
   - count_o=0, rd_valid_o=0000, stall_o=0, tail_o=0, rd_addr_o lanes 0/1/2/3.
2. Write 8, then 8 more (no pops):
   - count_o=16, tail_o=0 (wrapped), stall_o=1.
   - With dispatch_ready_i=1: pops 4/cycle, count_o 12→8; stall_o drops when count_o=8.
3. Wrap: head=14, count=4, ready=1:
   - rd_addr_o = 14,15,0,1; all lanes valid.
   - Next cycle: head=2, count_o=0.
4. count=3, ready=1:
   - With _EN: rd_valid_o=0111, pop_count_o=3, count→0.
   - Without _EN: rd_valid_o=0000, pop_count_o=0, count stays 3.
5. Simultaneous write and pop: count=5, wr_count_i=6, ready=1 → count_o=7, head+=4, tail+=6.
6. Flush priority:
   - flush_i with wr_count_i=4 and ready=1 → next cycle count_o=0, head=tail=0.
   - reset asserted together with flush_i → reset values.
